// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using double dabble, one bit per clock.
// Results are held until the next conversion completes.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {StIdle, StConv} state_t;

    state_t               state_q;
    logic [BIN_W-1:0]     sr_q;
    logic [BCD_W-1:0]     work_q;
    logic                 flag_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [BCD_W-1:0]       work_adj;
    logic [BCD_W+BIN_W:0]   shifted;
    logic                   carry;
    logic [BCD_W-1:0]       work_nxt;
    logic [BIN_W-1:0]       sr_nxt;

    // One double-dabble step: correct digits >= 5, then shift operand MSB into digit 0.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {work_adj, sr_q, 1'b0};
    end

    assign carry    = shifted[BCD_W+BIN_W];
    assign work_nxt = shifted[BCD_W+BIN_W-1:BIN_W];
    assign sr_nxt   = shifted[BIN_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            work_q  <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sr_q    <= bin;
                        work_q  <= '0;
                        flag_q  <= 1'b0;
                        cnt_q   <= CNT_W'(BIN_W);
                        state_q <= StConv;
                        busy    <= 1'b1;
                    end
                end
                StConv: begin
                    sr_q   <= sr_nxt;
                    work_q <= work_nxt;
                    flag_q <= flag_q | carry;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd     <= work_nxt;
                        ovf     <= flag_q | carry;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three parameterisations share clock and reset.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [15:0] bin0 = '0, bin1 = '0;
    logic [3:0]  bin2 = '0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [7:0]  bcd2;
    logic        ovf0, ovf1, ovf2;

    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] prev [3];

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0)
    );
    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
    );
    bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] get_bcd(input int s);
        case (s)
            0:       return {20'b0, bcd0};
            1:       return {24'b0, bcd1};
            default: return {32'b0, bcd2};
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int s);
        case (s)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_ovf(input int s);
        case (s)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    task automatic drive(input int s, input logic st, input logic [31:0] b);
        case (s)
            0: begin start0 = st; bin0 = b[15:0]; end
            1: begin start1 = st; bin1 = b[15:0]; end
            default: begin start2 = st; bin2 = b[3:0]; end
        endcase
    endtask

    // Called at a negedge with the DUT idle (or in its DONE cycle). Returns at the
    // DONE negedge when chained, otherwise one cycle later.
    task automatic do_conv(input int s, input logic [31:0] b, input int lat_exp,
                           input logic [39:0] bcd_exp, input logic ovf_exp, input string tag,
                           input bit chained, input bit mid_start, input logic [31:0] bmid);
        int lat = 0;
        int nb = 0;
        drive(s, 1'b1, b);
        @(negedge clk);
        drive(s, 1'b0, b);
        while (!get_done(s) && lat < lat_exp + 8) begin
            if (get_busy(s)) nb++;
            if (mid_start && lat == 2) drive(s, 1'b1, bmid);
            if (mid_start && lat == 3) drive(s, 1'b0, bmid);
            if (lat == lat_exp / 2) check_eq({tag, " hold"}, get_bcd(s), prev[s]);
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, lat, lat_exp);
        check_eq({tag, " busy_cycles"}, nb, lat_exp);
        check_eq({tag, " busy_at_done"}, get_busy(s), 1'b0);
        check_eq({tag, " bcd"}, get_bcd(s), bcd_exp);
        check_eq({tag, " ovf"}, get_ovf(s), ovf_exp);
        prev[s] = bcd_exp;
        if (!chained) begin
            @(negedge clk);
            check_eq({tag, " done_pulse"}, get_done(s), 1'b0);
            check_eq({tag, " bcd_held"}, get_bcd(s), bcd_exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev[i] = '0;
        #1;
        check_eq("rst busy", {busy0, busy1, busy2}, 3'b000);
        check_eq("rst done", {done0, done1, done2}, 3'b000);
        check_eq("rst ovf", {ovf0, ovf1, ovf2}, 3'b000);
        check_eq("rst bcd0", bcd0, 20'h0);
        check_eq("rst bcd2", bcd2, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst busy", busy0, 1'b0);
        check_eq("post_rst done", done0, 1'b0);

        do_conv(0, 32'd65535, 16, 40'h65535, 1'b0, "max16", 1'b0, 1'b0, 0);
        do_conv(0, 32'd0, 16, 40'h00000, 1'b0, "zero", 1'b1, 1'b0, 0);
        do_conv(0, 32'd9, 16, 40'h00009, 1'b0, "b2b_nine", 1'b0, 1'b0, 0);
        do_conv(0, 32'd1234, 16, 40'h01234, 1'b0, "ignore_start", 1'b0, 1'b1, 32'd4321);
        do_conv(0, 32'd10000, 16, 40'h10000, 1'b0, "d5_10000", 1'b0, 1'b0, 0);

        do_conv(1, 32'd12345, 16, 40'h2345, 1'b1, "d4_12345", 1'b0, 1'b0, 0);
        do_conv(1, 32'd9999, 16, 40'h9999, 1'b0, "d4_9999", 1'b0, 1'b0, 0);
        do_conv(1, 32'd10000, 16, 40'h0000, 1'b1, "d4_10000", 1'b0, 1'b0, 0);

        do_conv(2, 32'd4, 4, 40'h04, 1'b0, "w4_4", 1'b0, 1'b0, 0);
        do_conv(2, 32'd8, 4, 40'h08, 1'b0, "w4_8", 1'b0, 1'b0, 0);
        do_conv(2, 32'd15, 4, 40'h15, 1'b0, "w4_15", 1'b0, 1'b0, 0);

        // Abort a conversion with an asynchronous reset mid-cycle.
        drive(0, 1'b1, 32'd1234);
        @(negedge clk);
        drive(0, 1'b0, 32'd1234);
        repeat (6) @(negedge clk);
        check_eq("abort busy_before", busy0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort busy", busy0, 1'b0);
        check_eq("abort done", done0, 1'b0);
        check_eq("abort bcd", bcd0, 20'h0);
        check_eq("abort ovf", ovf0, 1'b0);
        check_eq("abort bcd1", bcd1, 16'h0);
        prev[0] = '0;
        prev[1] = '0;
        prev[2] = '0;
        @(negedge clk);
        check_eq("abort hold done", done0, 1'b0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("release busy", busy0, 1'b0);
            check_eq("release done", done0, 1'b0);
        end
        do_conv(0, 32'd42, 16, 40'h00042, 1'b0, "after_abort", 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 16, width of the binary input in bits (legal range 1..32).
REQ-002 Parameter DIGITS, default 5, number of BCD output digits (legal range 1..10).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request a conversion of BIN; sampled only while idle.
REQ-006 BIN  input  BIN_W  unsigned binary operand, captured on the accepting edge.
REQ-007 BUSY  output  1  high while a conversion is in progress.
REQ-008 DONE  output  1  one-cycle pulse marking a new valid BCD/OVF result.
REQ-009 BCD  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-010 OVF  output  1  high when the result did not fit in DIGITS digits.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and CONV.
REQ-012 In IDLE with START=1 on an edge, the block SHALL do four things on that edge: capture BIN into a shift register, clear the BCD working register and the overflow flag, load the iteration counter with BIN_W, and enter CONV.
REQ-013 START while in CONV SHALL be ignored and SHALL NOT alter the captured operand.
REQ-014 Each CONV cycle SHALL perform one double-dabble step.
- First, add 3 to every working digit whose value is >= 5.
- Then shift {working digits, operand} left by one, with the operand MSB entering digit 0 bit 0.
REQ-015 Any 1 shifted out of the top bit of the most significant working digit SHALL set the sticky internal overflow flag.
REQ-016 The counter SHALL decrement once per CONV cycle. The cycle in which it reaches 0 SHALL return the FSM to IDLE.
REQ-017 On the edge leaving CONV, the block SHALL load BCD from the final working digits, load OVF from the flag, and set DONE=1.
REQ-018 DONE SHALL be high for exactly one cycle per completed conversion.
REQ-019 Latency: START accepted at edge k gives BUSY=1 after edges k+1 .. k+BIN_W, and DONE=1 and BCD/OVF valid after edge k+BIN_W.
REQ-020 BUSY SHALL be a registered decode of state CONV.
REQ-021 BCD and OVF SHALL hold their last values until the next DONE. They SHALL NOT change during CONV.
REQ-022 START asserted in the cycle DONE is high SHALL be accepted, giving back-to-back throughput of one result per BIN_W cycles.
REQ-023 BCD SHALL equal BIN mod 10^DIGITS. OVF SHALL be 1 if and only if BIN >= 10^DIGITS.
REQ-024 Every BCD digit SHALL be in the range 0..9 at every DONE.
REQ-025 BIN=0 SHALL yield BCD=0, OVF=0 with the normal latency, with no shortened path.

Reset
REQ-026 RST_N=0 SHALL immediately force these values, independent of CLK: state IDLE, BUSY=0, DONE=0, OVF=0, BCD=0, counter=0, working registers=0.
REQ-027 Reset asserted mid-conversion SHALL abort it with no DONE pulse. After release, the first rising edge with START=1 SHALL begin a fresh conversion.
REQ-028 Reset deassertion SHALL take effect on a rising edge of CLK, with no spurious DONE or BUSY.

Verification
REQ-029 Default params, BIN=16'd65535, START one cycle -> BUSY high 16 cycles, then DONE=1 for 1 cycle, BCD=20'h65535, OVF=0.
REQ-030 Default params, BIN=0 then BIN=16'd9 back-to-back (second START in the DONE cycle) -> BCD=20'h00000, then 20'h00009 exactly 16 cycles later, OVF=0 both times.
REQ-031 BIN_W=16, DIGITS=4, BIN=16'd12345 -> BCD=16'h2345, OVF=1. BIN=16'd9999 -> BCD=16'h9999, OVF=0.
REQ-032 BIN_W=4, DIGITS=2 (4-bit value through the add-3 step), BIN=4, 8, 15 -> BCD=8'h04, 8'h08, 8'h15, latency 4 cycles each.
REQ-033 Default params, START with BIN=1234, then pulse RST_N low at cycle 7 -> all outputs 0 immediately, no DONE. A new START with BIN=42 -> BCD=20'h00042 after 16 cycles.
REQ-034 Default params, START re-asserted with a different BIN during CONV -> ignored, and the result matches the originally captured BIN.
